// File: rtl/xif_result_queue.sv
// ----------------------------------------------------------------------------
// xif_result_queue
//
// Coprocessor-side result queue. It sits between the FPU writeback stage and
// the CORE-V-XIF result interface. Completed integer-destination results
// {id, data, rd} enter a DEPTH-entry FIFO. They leave in completion order
// through the result_valid/result_ready handshake, so the FPU only stalls
// when the queue is full.
//
// Handshake semantics (both sides): a transfer happens on a rising clk edge
// where valid && ready. The producer holds its payload stable while valid is
// high and ready is low. ready never depends on the same side's valid. Here
// wb_ready depends only on registered occupancy. result_* come straight from
// the head register, so there is no wb_* -> result_* combinational path.
//
// Ports:
//   clk           clock; all state updates on the rising edge
//   reset_n       asynchronous active-low reset (clears pointers, count,
//                 overflow and the storage array)
//   flush         synchronous clear of all entries; wins over push/pop
//   wb_valid      FPU presents a result this cycle
//   wb_ready      queue can accept (not full; ignores same-cycle pop)
//   wb_id         id of the completing instruction
//   wb_data       result value
//   wb_rd         destination register
//   result_valid  head entry valid toward the CPU
//   result_ready  CPU accepts the head entry
//   result_id     head id
//   result_data   head data
//   result_rd     head rd
//   count         current occupancy, 0..DEPTH
//   overflow      sticky: a push was attempted while full
// ----------------------------------------------------------------------------
module xif_result_queue #(
  parameter  int DEPTH       = 4,
  parameter  int X_ID_WIDTH  = 4,
  parameter  int X_RFW_WIDTH = 32,
  localparam int CNT_W       = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   flush,
  input  logic                   wb_valid,
  output logic                   wb_ready,
  input  logic [X_ID_WIDTH-1:0]  wb_id,
  input  logic [X_RFW_WIDTH-1:0] wb_data,
  input  logic [4:0]             wb_rd,
  output logic                   result_valid,
  input  logic                   result_ready,
  output logic [X_ID_WIDTH-1:0]  result_id,
  output logic [X_RFW_WIDTH-1:0] result_data,
  output logic [4:0]             result_rd,
  output logic [CNT_W-1:0]       count,
  output logic                   overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [X_ID_WIDTH-1:0]  id_q   [DEPTH];
  logic [X_RFW_WIDTH-1:0] data_q [DEPTH];
  logic [4:0]             rd_q   [DEPTH];

  logic [AW-1:0]    wp_q, wp_d;
  logic [AW-1:0]    rp_q, rp_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;

  logic full;
  logic empty;
  logic push;
  logic pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = wb_valid && !full;
  assign pop   = !empty && result_ready;

  always_comb begin
    wp_d       = wp_q;
    rp_d       = rp_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (flush) begin
      // Any push or pop in the flush cycle is discarded.
      wp_d       = '0;
      rp_d       = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (push) wp_d = wp_q + AW'(1);
      if (pop)  rp_d = rp_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
      if (wb_valid && full) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp_q       <= '0;
      rp_q       <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      // The array is cleared so the head outputs are defined (zero) after reset.
      for (int i = 0; i < DEPTH; i++) begin
        id_q[i]   <= '0;
        data_q[i] <= '0;
        rd_q[i]   <= '0;
      end
    end else begin
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      // The write slot is never the live head while push is allowed, except
      // when the queue is empty, so a valid head is never overwritten.
      if (push && !flush) begin
        id_q[wp_q]   <= wb_id;
        data_q[wp_q] <= wb_data;
        rd_q[wp_q]   <= wb_rd;
      end
    end
  end

  assign wb_ready     = !full;
  assign result_valid = !empty;
  assign result_id    = id_q[rp_q];
  assign result_data  = data_q[rp_q];
  assign result_rd    = rd_q[rp_q];
  assign count        = count_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_xif_result_queue.sv
// ----------------------------------------------------------------------------
// tb_xif_result_queue
//
// Bench for xif_result_queue (DEPTH=4, X_ID_WIDTH=4, X_RFW_WIDTH=32).
// A table of one-cycle vectors gives the inputs and the state expected after
// the clock edge. Hand-written sequences cover the multi-cycle cases: reset,
// single pass with hold, streaming wrap, flush, and reset mid-stream.
// Inputs change on the falling edge. Outputs are sampled 1 time unit after
// the rising edge, or just before it for handshake observation.
// ----------------------------------------------------------------------------
module tb_xif_result_queue;

  localparam int DEPTH = 4;
  localparam int IDW   = 4;
  localparam int DW    = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           flush;
  logic           wb_valid;
  logic           wb_ready;
  logic [IDW-1:0] wb_id;
  logic [DW-1:0]  wb_data;
  logic [4:0]     wb_rd;
  logic           result_valid;
  logic           result_ready;
  logic [IDW-1:0] result_id;
  logic [DW-1:0]  result_data;
  logic [4:0]     result_rd;
  logic [CW-1:0]  count;
  logic           overflow;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] exp_q[$];

  xif_result_queue #(.DEPTH(DEPTH), .X_ID_WIDTH(IDW), .X_RFW_WIDTH(DW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .flush        (flush),
    .wb_valid     (wb_valid),
    .wb_ready     (wb_ready),
    .wb_id        (wb_id),
    .wb_data      (wb_data),
    .wb_rd        (wb_rd),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result_id    (result_id),
    .result_data  (result_data),
    .result_rd    (result_rd),
    .count        (count),
    .overflow     (overflow)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- vector table ----------------
  typedef struct {
    logic           fl;
    logic           wv;
    logic [IDW-1:0] id;
    logic [DW-1:0]  data;
    logic [4:0]     rd;
    logic           rr;
    logic           e_valid;
    logic           e_ready;
    logic [CW-1:0]  e_cnt;
    logic           e_ovf;
    logic           chk_head;
    logic [IDW-1:0] e_id;
    logic [DW-1:0]  e_data;
    logic [4:0]     e_rd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic fl, logic wv, logic [IDW-1:0] id,
                              logic [DW-1:0] data, logic [4:0] rd, logic rr,
                              logic e_valid, logic e_ready, logic [CW-1:0] e_cnt,
                              logic e_ovf, logic chk_head, logic [IDW-1:0] e_id,
                              logic [DW-1:0] e_data, logic [4:0] e_rd);
    vec_t v;
    v.fl = fl; v.wv = wv; v.id = id; v.data = data; v.rd = rd; v.rr = rr;
    v.e_valid = e_valid; v.e_ready = e_ready; v.e_cnt = e_cnt; v.e_ovf = e_ovf;
    v.chk_head = chk_head; v.e_id = e_id; v.e_data = e_data; v.e_rd = e_rd;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic fl, input logic wv, input logic [IDW-1:0] id,
                       input logic [DW-1:0] data, input logic [4:0] rd, input logic rr);
    @(negedge clk);
    flush        = fl;
    wb_valid     = wv;
    wb_id        = id;
    wb_data      = data;
    wb_rd        = rd;
    result_ready = rr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [IDW-1:0] id, input logic [DW-1:0] data, input logic [4:0] rd);
    drive(1'b0, 1'b1, id, data, rd, 1'b0);
    step();
  endtask

  task automatic check_head(input string tag, input logic [IDW-1:0] id,
                            input logic [DW-1:0] data, input logic [4:0] rd);
    chk({tag, "_id"},   DW'(result_id),   DW'(id));
    chk({tag, "_data"}, result_data,      data);
    chk({tag, "_rd"},   DW'(result_rd),   DW'(rd));
  endtask

  // ---------------- test ----------------
  initial begin
    reset_n      = 1'b0;
    flush        = 1'b0;
    wb_valid     = 1'b0;
    wb_id        = '0;
    wb_data      = '0;
    wb_rd        = '0;
    result_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    // Reset state
    chk("rst_count",    DW'(count),    0);
    chk("rst_valid",    DW'(result_valid), 0);
    chk("rst_ready",    DW'(wb_ready), 1);
    chk("rst_ovf",      DW'(overflow), 0);
    check_head("rst", 4'd0, 32'd0, 5'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Single pass: one-cycle latency, stable hold, then pop
    push_one(4'd3, 32'h3F80_0000, 5'd10);
    chk("sp_valid", DW'(result_valid), 1);
    chk("sp_count", DW'(count), 1);
    check_head("sp", 4'd3, 32'h3F80_0000, 5'd10);
    for (int c = 0; c < 5; c++) begin
      drive(1'b0, 1'b0, 4'd0, 32'd0, 5'd0, 1'b0);
      step();
      chk($sformatf("sp_hold%0d_valid", c), DW'(result_valid), 1);
      check_head($sformatf("sp_hold%0d", c), 4'd3, 32'h3F80_0000, 5'd10);
    end
    drive(1'b0, 1'b0, 4'd0, 32'd0, 5'd0, 1'b1);
    step();
    chk("sp_pop_valid", DW'(result_valid), 0);
    chk("sp_pop_count", DW'(count), 0);

    // Table: fill, overflow, push+pop at full, drain, underflow, flush, stream
    //             fl  wv  id    data          rd     rr  val rdy cnt ovf chk id   data          rd
    vecs.push_back(mk(0, 1, 4'd0, 32'h100, 5'd1,  0,  1,  1,  1,  0,  1, 4'd0, 32'h100, 5'd1));
    vecs.push_back(mk(0, 1, 4'd1, 32'h101, 5'd2,  0,  1,  1,  2,  0,  1, 4'd0, 32'h100, 5'd1));
    vecs.push_back(mk(0, 1, 4'd2, 32'h102, 5'd3,  0,  1,  1,  3,  0,  1, 4'd0, 32'h100, 5'd1));
    vecs.push_back(mk(0, 1, 4'd3, 32'h103, 5'd4,  0,  1,  0,  4,  0,  1, 4'd0, 32'h100, 5'd1));
    vecs.push_back(mk(0, 1, 4'd7, 32'h777, 5'd31, 0,  1,  0,  4,  1,  1, 4'd0, 32'h100, 5'd1));
    vecs.push_back(mk(0, 1, 4'd7, 32'h777, 5'd31, 1,  1,  1,  3,  1,  1, 4'd1, 32'h101, 5'd2));
    vecs.push_back(mk(0, 0, 4'd0, 32'h0,   5'd0,  1,  1,  1,  2,  1,  1, 4'd2, 32'h102, 5'd3));
    vecs.push_back(mk(0, 0, 4'd0, 32'h0,   5'd0,  1,  1,  1,  1,  1,  1, 4'd3, 32'h103, 5'd4));
    vecs.push_back(mk(0, 0, 4'd0, 32'h0,   5'd0,  1,  0,  1,  0,  1,  0, 4'd0, 32'h0,   5'd0));
    vecs.push_back(mk(0, 0, 4'd0, 32'h0,   5'd0,  1,  0,  1,  0,  1,  0, 4'd0, 32'h0,   5'd0));
    vecs.push_back(mk(1, 0, 4'd0, 32'h0,   5'd0,  0,  0,  1,  0,  0,  0, 4'd0, 32'h0,   5'd0));
    vecs.push_back(mk(0, 1, 4'd9, 32'h909, 5'd9,  1,  1,  1,  1,  0,  1, 4'd9, 32'h909, 5'd9));
    vecs.push_back(mk(0, 1, 4'hA, 32'hA0A, 5'd11, 1,  1,  1,  1,  0,  1, 4'hA, 32'hA0A, 5'd11));
    vecs.push_back(mk(0, 0, 4'd0, 32'h0,   5'd0,  1,  0,  1,  0,  0,  0, 4'd0, 32'h0,   5'd0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].fl, vecs[i].wv, vecs[i].id, vecs[i].data, vecs[i].rd, vecs[i].rr);
      step();
      chk($sformatf("v%0d_valid", i), DW'(result_valid), DW'(vecs[i].e_valid));
      chk($sformatf("v%0d_ready", i), DW'(wb_ready),     DW'(vecs[i].e_ready));
      chk($sformatf("v%0d_count", i), DW'(count),        DW'(vecs[i].e_cnt));
      chk($sformatf("v%0d_ovf", i),   DW'(overflow),     DW'(vecs[i].e_ovf));
      if (vecs[i].chk_head)
        check_head($sformatf("v%0d", i), vecs[i].e_id, vecs[i].e_data, vecs[i].e_rd);
    end

    // Streaming wrap: push and pop every cycle, scoreboard on data
    begin
      int popped = 0;
      for (int c = 0; c < 20 + 10; c++) begin
        logic [DW-1:0] d;
        d = 32'hA000 + DW'(c);
        if (c < 20) drive(1'b0, 1'b1, d[IDW-1:0], d, 5'(c), 1'b1);
        else        drive(1'b0, 1'b0, 4'd0, 32'd0, 5'd0, 1'b1);
        #1;
        if (c < 20) chk($sformatf("st%0d_ready", c), DW'(wb_ready), 1);
        if (result_valid && result_ready) begin
          if (exp_q.size() == 0) begin
            chk($sformatf("st%0d_unexpected_pop", c), result_data, 32'hFFFF_FFFF);
          end else begin
            logic [DW-1:0] e;
            e = exp_q.pop_front();
            chk($sformatf("st%0d_data", c), result_data, e);
            chk($sformatf("st%0d_id", c), DW'(result_id), DW'(e[IDW-1:0]));
            popped++;
          end
        end
        if (wb_valid && wb_ready) exp_q.push_back(wb_data);
        step();
        chk($sformatf("st%0d_cnt_le1", c), DW'(count <= CW'(1)), 1);
        if (c >= 20 && !result_valid) break;
      end
      chk("st_popped", DW'(popped), 20);
      chk("st_left",   DW'(exp_q.size()), 0);
    end

    // Flush with concurrent push and pop
    push_one(4'd1, 32'h11, 5'd1);
    push_one(4'd2, 32'h22, 5'd2);
    push_one(4'd3, 32'h33, 5'd3);
    chk("fl_pre_count", DW'(count), 3);
    drive(1'b1, 1'b1, 4'd8, 32'h88, 5'd8, 1'b1);
    step();
    chk("fl_count", DW'(count), 0);
    chk("fl_valid", DW'(result_valid), 0);
    chk("fl_ovf",   DW'(overflow), 0);
    chk("fl_ready", DW'(wb_ready), 1);
    push_one(4'd5, 32'h55, 5'd5);
    chk("fl_post_count", DW'(count), 1);
    check_head("fl_post", 4'd5, 32'h55, 5'd5);

    // Reset mid-stream with two entries: takes effect without a clock edge
    push_one(4'd6, 32'h66, 5'd6);
    chk("mr_pre_count", DW'(count), 2);
    drive(1'b0, 1'b0, 4'd0, 32'd0, 5'd0, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    chk("mr_count", DW'(count), 0);
    chk("mr_valid", DW'(result_valid), 0);
    chk("mr_ready", DW'(wb_ready), 1);
    chk("mr_ovf",   DW'(overflow), 0);
    check_head("mr", 4'd0, 32'd0, 5'd0);
    @(negedge clk);
    reset_n = 1'b1;
    step();
    chk("mr_after_valid", DW'(result_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Bound total runtime so the bench always ends.
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
